// File: rtl/fifo_drain_checker.sv
// fifo_drain_checker: drains NUM_CH output FIFOs in order after a settle delay and checks each word against expected memory
//   clk, reset (async, active-low), start                   : control
//   exp_count                                               : expected word count per channel, ch0 in LSBs
//   ch_empty / ch_deq / ch_data                             : FIFO side; data valid the cycle after ch_deq
//   exp_rd_en / exp_rd_ch / exp_rd_addr / exp_rd_data       : expected-memory read port, data one cycle after enable
//   busy, done, pass                                        : run status; pass only meaningful while done
//   got_count, mismatch_cnt, short_fail, over_fail, mismatch_fail : per-channel results, held until next start
module fifo_drain_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH = 2,
  parameter int EXP_ADDR_WIDTH = 10,
  parameter int CNT_WIDTH = 16,
  parameter int SETTLE_CYCLES = 1124,
  localparam int CHW = $clog2(NUM_CH > 1 ? NUM_CH : 2)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_CH*CNT_WIDTH-1:0]    exp_count,
  input  logic [NUM_CH-1:0]              ch_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
  output logic [NUM_CH-1:0]              ch_deq,
  output logic                           exp_rd_en,
  output logic [CHW-1:0]                 exp_rd_ch,
  output logic [EXP_ADDR_WIDTH-1:0]      exp_rd_addr,
  input  logic [DATA_WIDTH-1:0]          exp_rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [NUM_CH*CNT_WIDTH-1:0]    got_count,
  output logic [NUM_CH*CNT_WIDTH-1:0]    mismatch_cnt,
  output logic [NUM_CH-1:0]              short_fail,
  output logic [NUM_CH-1:0]              over_fail,
  output logic [NUM_CH-1:0]              mismatch_fail
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT, CHECK, CMP, VERDICT, DONE} state_t;
  state_t st, nxt;
  logic [SW-1:0] scnt;
  logic [CHW-1:0] ch;
  logic [EXP_ADDR_WIDTH-1:0] idx;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] got, mis;
  logic [CNT_WIDTH-1:0] cur_exp, cur_got, cur_mis;
  logic [DATA_WIDTH-1:0] cur_data;
  logic last, cmp_en;
  assign cur_exp = exp_count[ch*CNT_WIDTH +: CNT_WIDTH];
  assign cur_data = ch_data[ch*DATA_WIDTH +: DATA_WIDTH];
  assign cur_got = got[ch];
  assign cur_mis = mis[ch];
  assign last = ch == CHW'(NUM_CH - 1);
  // words beyond the expected count are only counted, never compared
  assign cmp_en = 32'(idx) < 32'(cur_exp);
  assign got_count = got;
  assign mismatch_cnt = mis;
  assign busy = st inside {WAIT, CHECK, CMP, VERDICT};
  assign done = st == DONE;
  assign pass = done & ~|{short_fail, over_fail, mismatch_fail};
  assign exp_rd_ch = exp_rd_en ? ch : '0;
  assign exp_rd_addr = exp_rd_en ? idx : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    exp_rd_en = 1'b0;
    case (st)
      IDLE, DONE: nxt = start ? WAIT : st;
      WAIT: nxt = scnt == SW'(1) ? CHECK : WAIT;
      CHECK: begin
        exp_rd_en = ~ch_empty[ch];
        nxt = ch_empty[ch] ? VERDICT : CMP;
      end
      CMP: nxt = CHECK;
      VERDICT: nxt = last ? DONE : CHECK;
      default: nxt = IDLE;
    endcase
    ch_deq = exp_rd_en ? NUM_CH'(1) << ch : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scnt <= '0;
      ch <= '0;
      idx <= '0;
      got <= '0;
      mis <= '0;
      short_fail <= '0;
      over_fail <= '0;
      mismatch_fail <= '0;
    end else begin
      case (st)
        IDLE, DONE: if (start) begin
          scnt <= SW'(SETTLE_CYCLES);
          got <= '0;
          mis <= '0;
          short_fail <= '0;
          over_fail <= '0;
          mismatch_fail <= '0;
        end
        WAIT: begin
          scnt <= scnt - SW'(1);
          ch <= '0;
          idx <= '0;
        end
        CMP: begin
          idx <= idx + EXP_ADDR_WIDTH'(1);
          got[ch] <= cur_got + CNT_WIDTH'(~&cur_got);
          mis[ch] <= cur_mis + CNT_WIDTH'(cmp_en && cur_data != exp_rd_data && ~&cur_mis);
        end
        VERDICT: begin
          short_fail[ch] <= cur_got < cur_exp;
          over_fail[ch] <= cur_got > cur_exp;
          mismatch_fail[ch] <= |cur_mis;
          if (!last) begin
            ch <= ch + CHW'(1);
            idx <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fifo_drain_checker.sv
// tb_fifo_drain_checker: directed runs with a result scoreboard checked on each done rising edge
module tb_fifo_drain_checker;
  logic clk = 0, reset = 0, start = 0;
  logic [31:0] exp_count = '0;
  logic [1:0] ch_empty = 2'b11, ch_deq;
  logic [15:0] ch_data = '0;
  logic exp_rd_en;
  logic [0:0] exp_rd_ch;
  logic [9:0] exp_rd_addr;
  logic [7:0] exp_rd_data = '0;
  logic busy, done, pass;
  logic [31:0] got_count, mismatch_cnt;
  logic [1:0] short_fail, over_fail, mismatch_fail;
  typedef struct {int g0; int g1; int m0; int m1; int sf; int of; int mf; int ps;} res_t;
  res_t sb[$];
  res_t e;
  res_t t1 = '{2, 3, 0, 0, 0, 0, 0, 1};
  logic [7:0] fq0[$], fq1[$];
  logic [7:0] mem0[1024], mem1[1024];
  logic [7:0] d0, d1;
  logic done_q = 0, deq_q = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fifo_drain_checker #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_count(exp_count),
    .ch_empty(ch_empty), .ch_data(ch_data), .ch_deq(ch_deq),
    .exp_rd_en(exp_rd_en), .exp_rd_ch(exp_rd_ch), .exp_rd_addr(exp_rd_addr),
    .exp_rd_data(exp_rd_data), .busy(busy), .done(done), .pass(pass),
    .got_count(got_count), .mismatch_cnt(mismatch_cnt), .short_fail(short_fail),
    .over_fail(over_fail), .mismatch_fail(mismatch_fail));
  always @(posedge clk) begin
    d0 = ch_data[7:0];
    d1 = ch_data[15:8];
    if (ch_deq[0] && fq0.size() > 0) d0 = fq0.pop_front();
    if (ch_deq[1] && fq1.size() > 0) d1 = fq1.pop_front();
    ch_data <= {d1, d0};
    ch_empty <= {fq1.size() == 0, fq0.size() == 0};
    exp_rd_data <= exp_rd_ch[0] ? mem1[exp_rd_addr] : mem0[exp_rd_addr];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask
  always @(negedge clk) begin
    if (|ch_deq) begin
      checks++;
      if (deq_q) begin
        errors++;
        $display("FAIL deq_consecutive: ch_deq %b high two cycles running", ch_deq);
      end
    end
    deq_q = |ch_deq;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done rose with no expectation queued");
      end else begin
        e = sb.pop_front();
        chk("got_count0", 32'(got_count[15:0]), e.g0);
        chk("got_count1", 32'(got_count[31:16]), e.g1);
        chk("mismatch_cnt0", 32'(mismatch_cnt[15:0]), e.m0);
        chk("mismatch_cnt1", 32'(mismatch_cnt[31:16]), e.m1);
        chk("short_fail", 32'(short_fail), e.sf);
        chk("over_fail", 32'(over_fail), e.of);
        chk("mismatch_fail", 32'(mismatch_fail), e.mf);
        chk("pass", 32'(pass), e.ps);
        chk("busy_at_done", 32'(busy), 0);
      end
    end
    done_q = done;
  end
  task automatic setup_t1();
    fq0 = '{8'h11, 8'h22};
    fq1 = '{8'h33, 8'h44, 8'h55};
    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h00; mem0[3] = 8'h00;
    mem1[0] = 8'h33; mem1[1] = 8'h44; mem1[2] = 8'h55;
    exp_count = {16'd3, 16'd2};
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done %b after %0d cycles, required 1", done, n);
    end
    @(negedge clk);
  endtask
  task automatic go(input res_t r);
    sb.push_back(r);
    pulse_start();
    wait_done();
  endtask
  initial begin
    int lat, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_deq", 32'(ch_deq), 0);
    chk("rst_rd_en", 32'(exp_rd_en), 0);
    chk("rst_got", got_count, 0);
    reset = 1;
    setup_t1();
    sb.push_back(t1);
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    lat = 1;
    while (!(|ch_deq) && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("first_deq_latency", lat, 5);
    chk("first_deq_ch0", 32'(ch_deq), 1);
    chk("first_rd_en", 32'(exp_rd_en), 1);
    wait_done();
    setup_t1();
    fq0 = '{8'h11, 8'h5A};
    mem0[1] = 8'h5B;
    go('{2, 3, 1, 0, 0, 0, 1, 0});
    setup_t1();
    fq1 = '{8'h33};
    go('{2, 1, 0, 0, 2, 0, 0, 0});
    setup_t1();
    fq0 = '{8'h11, 8'h22, 8'h33, 8'h99};
    mem0[2] = 8'h33; mem0[3] = 8'hFF;
    exp_count[15:0] = 16'd3;
    go('{4, 3, 0, 0, 0, 1, 0, 0});
    setup_t1();
    pulse_start();
    n = 0;
    while (!(|ch_deq) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_deq_seen", 32'(|ch_deq), 1);
    reset = 0;
    #1;
    chk("t5_deq_drop", 32'(ch_deq), 0);
    chk("t5_rd_en_drop", 32'(exp_rd_en), 0);
    chk("t5_busy_drop", 32'(busy), 0);
    chk("t5_got_clear", got_count, 0);
    chk("t5_mis_clear", mismatch_cnt, 0);
    @(negedge clk) reset = 1;
    fq0.delete();
    fq1.delete();
    setup_t1();
    go(t1);
    setup_t1();
    sb.push_back(t1);
    pulse_start();
    n = 0;
    while (got_count[31:16] == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1;
    @(negedge clk) start = 0;
    chk("t6_busy_held", 32'(busy), 1);
    chk("t6_no_clear", 32'(got_count[31:16] != 0), 1);
    chk("t6_ch0_kept", 32'(got_count[15:0]), 2);
    wait_done();
    fq0.delete();
    fq1.delete();
    exp_count = '0;
    go('{0, 0, 0, 0, 0, 0, 0, 1});
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
